// File: rtl/arb_pixel_fifo_if.sv
// arb_pixel_fifo_if
//  Bundles the arbiter write side, the master/DMA read side and the status
//  flags of the pixel FIFO.
//  slave  modport : the FIFO itself (takes slvx_*, ready and ovf_clr; drives flags and read data)
//  master modport : whatever feeds and drains the FIFO (arbiter + master engine)
interface arb_pixel_fifo_if #(
  parameter int DW    = 32,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          slvx_data_valid;
  logic [DW-1:0] slvx_data;
  logic [1:0]    slvx_mode;
  logic [7:0]    slvx_proc_val;
  logic          data_source;
  logic          fifo_full;
  logic          fifo_afull;
  logic          mstr_rd_valid;
  logic          mstr_rd_ready;
  logic [DW-1:0] mstr_rd_data;
  logic [1:0]    mstr_rd_mode;
  logic [7:0]    mstr_rd_proc_val;
  logic          mstr_rd_source;
  logic [CW-1:0] fifo_count;
  logic          fifo_ovf;
  logic          ovf_clr;

  modport slave (
    input  slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, data_source,
    input  mstr_rd_ready, ovf_clr,
    output fifo_full, fifo_afull, mstr_rd_valid, mstr_rd_data, mstr_rd_mode,
    output mstr_rd_proc_val, mstr_rd_source, fifo_count, fifo_ovf
  );

  modport master (
    output slvx_data_valid, slvx_data, slvx_mode, slvx_proc_val, data_source,
    output mstr_rd_ready, ovf_clr,
    input  fifo_full, fifo_afull, mstr_rd_valid, mstr_rd_data, mstr_rd_mode,
    input  mstr_rd_proc_val, mstr_rd_source, fifo_count, fifo_ovf
  );
endinterface

// File: rtl/arb_pixel_fifo.sv
// arb_pixel_fifo
//  In-order buffer behind the slave arbiter. Each non-idle arbitrated word is
//  stored with its sideband (source, mode, proc value); the head entry is shown
//  first-word-fall-through on a valid/ready read port. fifo_full / fifo_afull
//  back-pressure the arbiter; words arriving while full are dropped and flagged
//  in the sticky fifo_ovf bit.
//  Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - arb_pixel_fifo_if.slave: slvx_* write side, mstr_rd_* read side,
//            fifo_count / fifo_full / fifo_afull / fifo_ovf status, ovf_clr
module arb_pixel_fifo #(
  parameter int DW        = 32,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  arb_pixel_fifo_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(DEPTH - AF_MARGIN);

  typedef struct packed {
    logic          src;
    logic [1:0]    mode;
    logic [7:0]    pv;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic          r_full, r_afull, r_ovf;

  logic          w_empty, w_word, w_wr_en, w_rd_en;
  logic [PW-1:0] w_cnt_nxt;
  entry_t        w_wr_ent, w_head;

  // Extra pointer MSB separates full from empty when the low bits match.
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  // Idle (mode 00) words are not real traffic and never occupy an entry.
  assign w_word   = bus.slvx_data_valid && (bus.slvx_mode != 2'b00);
  // Full is judged on the registered flag only: a same-cycle read does not
  // make room for the incoming word.
  assign w_wr_en  = w_word && !r_full;
  assign w_rd_en  = !w_empty && bus.mstr_rd_ready;

  assign w_wr_ent = '{src: bus.data_source, mode: bus.slvx_mode,
                      pv: bus.slvx_proc_val, data: bus.slvx_data};

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_en && !w_rd_en)      w_cnt_nxt = r_count + PW'(1);
    else if (!w_wr_en && w_rd_en) w_cnt_nxt = r_count - PW'(1);
  end

  // Storage is deliberately left out of reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_afull  <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_LVL);
      r_afull <= (w_cnt_nxt >= AF_LVL);
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_ovf <= 1'b0;
    else if (w_word && r_full) r_ovf <= 1'b1;
    else if (bus.ovf_clr)      r_ovf <= 1'b0;
  end

  // Zero-gate the head so stale storage never leaks out while empty
  // (this also gives all-zero read outputs during reset).
  assign w_head = w_empty ? entry_t'('0) : r_mem[r_rd_ptr[AW-1:0]];

  assign bus.mstr_rd_valid    = !w_empty;
  assign bus.mstr_rd_data     = w_head.data;
  assign bus.mstr_rd_mode     = w_head.mode;
  assign bus.mstr_rd_proc_val = w_head.pv;
  assign bus.mstr_rd_source   = w_head.src;
  assign bus.fifo_count       = r_count;
  assign bus.fifo_full        = r_full;
  assign bus.fifo_afull       = r_afull;
  assign bus.fifo_ovf         = r_ovf;
endmodule
